rle_instruction_encoder: RTL and testbench

- Run-length encoder that converts a raster stream of 9-bit RGB pixels into the 20-bit pixel instructions the player's instruction decoder consumes.
- It is the write-side counterpart of that decoder.
- It sits between a pixel source (video capture or test-pattern generator) and the flash image writer / QSPI programming path.
- Consecutive identical pixels are merged into one instruction, with runs always broken at line end and at a maximum length.

---
 rtl/rle_instruction_encoder_if.sv | 20 ++
 rtl/rle_instruction_encoder.sv | 97 +++++++++
 tb/tb_rle_instruction_encoder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rle_instruction_encoder_if.sv
// rle_instruction_encoder_if: pixel stream in, instruction stream out, plus busy status.
interface rle_instruction_encoder_if;
    logic [8:0]  pix_in;
    logic        pix_valid;
    logic        pix_eol;
    logic        pix_eof;
    logic        pix_ready;
    logic [19:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;
    modport master (
        output pix_in, pix_valid, pix_eol, pix_eof, instr_ready,
        input  pix_ready, instr_out, instr_valid, busy
    );
    modport slave (
        input  pix_in, pix_valid, pix_eol, pix_eof, instr_ready,
        output pix_ready, instr_out, instr_valid, busy
    );
endinterface

// File: rtl/rle_instruction_encoder.sv
// rle_instruction_encoder: merges equal raster pixels into {length[10:0], colour[8:0]} instructions.
// Defining RLE_FRAME_MARKER_EN appends a zero-length marker instruction after each frame.
module rle_instruction_encoder #(
    parameter int MAX_RUN = 2047
) (
    input logic clk,
    input logic rst,
    rle_instruction_encoder_if.slave bus
);
`ifdef RLE_FRAME_MARKER_EN
    typedef enum logic [1:0] {IDLE, RUN, PEND, MARK} state_t;
    localparam state_t EOF_NEXT = MARK;
`else
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
    localparam state_t EOF_NEXT = IDLE;
`endif
    state_t      state_q;
    logic [8:0]  c_q;
    logic [10:0] n_q;
    logic [19:0] out_q;
    logic [19:0] pend_q;
    logic        ov_q;
    logic        mk_q;
    logic        free;
    logic        take;
    logic        eol;
    logic [10:0] n_inc;
    assign free = !ov_q || bus.instr_ready;
    assign bus.pix_ready = !rst && (state_q == IDLE || state_q == RUN) && free;
    assign take = bus.pix_valid && bus.pix_ready;
    assign eol = bus.pix_eol || bus.pix_eof;
    assign n_inc = n_q + 11'd1;
    assign bus.instr_out = out_q;
    assign bus.instr_valid = ov_q;
    assign bus.busy = (state_q != IDLE) || ov_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            n_q     <= '0;
            out_q   <= '0;
            pend_q  <= '0;
            ov_q    <= 1'b0;
            mk_q    <= 1'b0;
        end else begin
            if (ov_q && bus.instr_ready) ov_q <= 1'b0;
            case (state_q)
                IDLE: if (take) begin
                    if (eol) begin
                        out_q   <= {11'd1, bus.pix_in};
                        ov_q    <= 1'b1;
                        state_q <= bus.pix_eof ? EOF_NEXT : IDLE;
                    end else begin
                        c_q     <= bus.pix_in;
                        n_q     <= 11'd1;
                        state_q <= RUN;
                    end
                end
                RUN: if (take) begin
                    if (bus.pix_in == c_q) begin
                        if (eol || n_inc == 11'(MAX_RUN)) begin
                            out_q   <= {n_inc, c_q};
                            ov_q    <= 1'b1;
                            state_q <= bus.pix_eof ? EOF_NEXT : IDLE;
                        end else begin
                            n_q <= n_inc;
                        end
                    end else begin
                        out_q <= {n_q, c_q};
                        ov_q  <= 1'b1;
                        c_q   <= bus.pix_in;
                        n_q   <= 11'd1;
                        // a colour change on the line's last pixel closes two runs at once
                        if (eol) begin
                            pend_q  <= {11'd1, bus.pix_in};
                            mk_q    <= bus.pix_eof;
                            state_q <= PEND;
                        end
                    end
                end
                PEND: if (free) begin
                    out_q   <= pend_q;
                    ov_q    <= 1'b1;
                    state_q <= mk_q ? EOF_NEXT : IDLE;
                end
`ifdef RLE_FRAME_MARKER_EN
                MARK: if (free) begin
                    out_q   <= '0;
                    ov_q    <= 1'b1;
                    state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rle_instruction_encoder.sv
// tb_rle_instruction_encoder: cycle vectors, corner sequences and randomized lines against a run-splitting model.
module tb_rle_instruction_encoder;
    logic        clk = 1'b0;
    logic        rst, sel, pv, pe, pf, ir, rnd;
    logic [8:0]  px;
    logic        pr, iv, bz;
    logic [19:0] io;
    int          total = 0;
    int          bad = 0;
    logic [10:0] pix_q[$];
    logic [19:0] obs_q[$];
    logic [8:0]  pal[3] = '{9'h0AA, 9'h155, 9'h1C7};
    rle_instruction_encoder_if ifa ();
    rle_instruction_encoder_if ifb ();
    rle_instruction_encoder dut_a (.clk(clk), .rst(rst), .bus(ifa));
    rle_instruction_encoder #(.MAX_RUN(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    assign ifa.pix_in = px;
    assign ifa.pix_valid = pv && !sel;
    assign ifa.pix_eol = pe;
    assign ifa.pix_eof = pf;
    assign ifa.instr_ready = ir;
    assign ifb.pix_in = px;
    assign ifb.pix_valid = pv && sel;
    assign ifb.pix_eol = pe;
    assign ifb.pix_eof = pf;
    assign ifb.instr_ready = ir;
    assign pr = sel ? ifb.pix_ready : ifa.pix_ready;
    assign iv = sel ? ifb.instr_valid : ifa.instr_valid;
    assign bz = sel ? ifb.busy : ifa.busy;
    assign io = sel ? ifb.instr_out : ifa.instr_out;
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (!rst) begin
            if (pv && pr) pix_q.push_back({pf, pe, px});
            if (iv && ir) obs_q.push_back(io);
        end
    end
    function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endfunction
    task automatic send(input logic [8:0] p, input logic e, input logic f);
        int  t;
        logic acc;
        t = 0;
        acc = 1'b0;
        pv = 1'b1; px = p; pe = e; pf = f;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = pr;
            @(posedge clk);
            #1;
            if (rnd) ir = $urandom_range(0, 3) != 0;
            t++;
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
        pv = 1'b0; pe = 1'b0; pf = 1'b0;
    endtask
    task automatic drain();
        logic done;
        done = 1'b0;
        pv = 1'b0;
        ir = 1'b1;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            done = !bz;
            @(posedge clk);
            #1;
        end
        chk("drain_idle", 32'(done), 32'd1);
    endtask
    // Model: split each completed line into maximal equal-colour runs, then chop runs at mr.
    task automatic check_stream(input string n, input int mr);
        logic [19:0] exp_q[$];
        logic [8:0]  line[$];
        int i, j, len, k;
        foreach (pix_q[m]) begin
            line.push_back(pix_q[m][8:0]);
            if (pix_q[m][9] || pix_q[m][10]) begin
                i = 0;
                while (i < line.size()) begin
                    j = i;
                    while (j < line.size() && line[j] == line[i]) j++;
                    len = j - i;
                    while (len > 0) begin
                        k = (len > mr) ? mr : len;
                        exp_q.push_back({11'(k), line[i]});
                        len -= k;
                    end
                    i = j;
                end
                line.delete();
`ifdef RLE_FRAME_MARKER_EN
                if (pix_q[m][10]) exp_q.push_back(20'h00000);
`endif
            end
        end
        chk({n, "_count"}, obs_q.size(), exp_q.size());
        foreach (exp_q[m]) chk($sformatf("%s_instr%0d", n, m), (m < obs_q.size()) ? obs_q[m] : 32'hDEAD, exp_q[m]);
        pix_q.delete();
        obs_q.delete();
    endtask
    task automatic run_random(input int s, input int mr);
        int len;
        logic [8:0] cur;
        sel = s[0];
        rnd = 1'b1;
        for (int l = 0; l < 40; l++) begin
            len = $urandom_range(1, 12);
            cur = pal[$urandom_range(0, 2)];
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) < 4) cur = pal[$urandom_range(0, 2)];
                send(cur, k == len - 1, (k == len - 1) && ($urandom_range(0, 7) == 0));
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                        ir = $urandom_range(0, 3) != 0;
                    end
                end
            end
        end
        rnd = 1'b0;
        drain();
        check_stream($sformatf("rand%0d", s), mr);
    endtask
    typedef struct packed {
        logic        v;
        logic [8:0]  p;
        logic        e;
        logic        r;
        logic        xpr;
        logic        xiv;
        logic [19:0] xo;
        logic        xbz;
    } vec_t;
    vec_t tv[20];
    initial begin
        tv[0]  = '{1'b1, 9'h1C0, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00000, 1'b0};
        tv[1]  = '{1'b1, 9'h1C0, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00000, 1'b1};
        tv[2]  = '{1'b1, 9'h1C0, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00000, 1'b1};
        tv[3]  = '{1'b1, 9'h1C0, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00000, 1'b1};
        tv[4]  = '{1'b1, 9'h1C0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h00000, 1'b1};
        tv[5]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b1, 20'h00BC0, 1'b1};
        tv[6]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00000, 1'b0};
        tv[7]  = '{1'b1, 9'h007, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00000, 1'b0};
        tv[8]  = '{1'b1, 9'h007, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00000, 1'b1};
        tv[9]  = '{1'b1, 9'h007, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00000, 1'b1};
        tv[10] = '{1'b1, 9'h038, 1'b1, 1'b1, 1'b1, 1'b0, 20'h00000, 1'b1};
        tv[11] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 20'h00607, 1'b1};
        tv[12] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b1, 20'h00238, 1'b1};
        tv[13] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00000, 1'b0};
        tv[14] = '{1'b1, 9'h011, 1'b1, 1'b0, 1'b1, 1'b0, 20'h00000, 1'b0};
        tv[15] = '{1'b1, 9'h022, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00211, 1'b1};
        tv[16] = '{1'b1, 9'h022, 1'b1, 1'b0, 1'b0, 1'b1, 20'h00211, 1'b1};
        tv[17] = '{1'b1, 9'h022, 1'b1, 1'b1, 1'b1, 1'b1, 20'h00211, 1'b1};
        tv[18] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b1, 20'h00222, 1'b1};
        tv[19] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00000, 1'b0};
        rst = 1'b1; sel = 1'b0; pv = 1'b0; pe = 1'b0; pf = 1'b0; ir = 1'b1; rnd = 1'b0; px = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_pix_ready", 32'(pr), 32'd0);
        chk("rst_instr_valid", 32'(iv), 32'd0);
        chk("rst_instr_out", 32'(io), 32'd0);
        chk("rst_busy", 32'(bz), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pv = tv[i].v; px = tv[i].p; pe = tv[i].e; ir = tv[i].r;
            @(negedge clk);
            chk($sformatf("vec%0d_pix_ready", i), 32'(pr), 32'(tv[i].xpr));
            chk($sformatf("vec%0d_instr_valid", i), 32'(iv), 32'(tv[i].xiv));
            if (tv[i].xiv) chk($sformatf("vec%0d_instr_out", i), 32'(io), 32'(tv[i].xo));
            chk($sformatf("vec%0d_busy", i), 32'(bz), 32'(tv[i].xbz));
            @(posedge clk);
            #1;
        end
        pv = 1'b0; pe = 1'b0;
        check_stream("vec", 2047);
        send(9'h0AA, 1'b1, 1'b1);
        drain();
`ifdef RLE_FRAME_MARKER_EN
        chk("marker_count", obs_q.size(), 32'd2);
        chk("marker_instr1", (obs_q.size() > 1) ? obs_q[1] : 32'hDEAD, 32'h00000);
`else
        chk("marker_count", obs_q.size(), 32'd1);
`endif
        chk("marker_instr0", (obs_q.size() > 0) ? obs_q[0] : 32'hDEAD, 32'h002AA);
        check_stream("marker", 2047);
        repeat (7) send(9'h055, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pix_ready", 32'(pr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_instr_valid", 32'(iv), 32'd0);
        chk("midrst_busy", 32'(bz), 32'd0);
        chk("midrst_pix_ready_after", 32'(pr), 32'd1);
        chk("midrst_no_emit", obs_q.size(), 32'd0);
        pix_q.delete();
        obs_q.delete();
        @(posedge clk);
        #1;
        send(9'h055, 1'b0, 1'b0);
        send(9'h055, 1'b0, 1'b0);
        send(9'h055, 1'b1, 1'b0);
        drain();
        chk("postrst_count", obs_q.size(), 32'd1);
        chk("postrst_instr", (obs_q.size() > 0) ? obs_q[0] : 32'hDEAD, 32'h00655);
        pix_q.delete();
        obs_q.delete();
        sel = 1'b1;
        for (int k = 0; k < 10; k++) send(9'h1FF, k == 9, 1'b0);
        drain();
        chk("maxrun_count", obs_q.size(), 32'd3);
        chk("maxrun_instr0", (obs_q.size() > 0) ? obs_q[0] : 32'hDEAD, 32'h009FF);
        chk("maxrun_instr1", (obs_q.size() > 1) ? obs_q[1] : 32'hDEAD, 32'h009FF);
        chk("maxrun_instr2", (obs_q.size() > 2) ? obs_q[2] : 32'hDEAD, 32'h005FF);
        check_stream("maxrun", 4);
        run_random(0, 2047);
        run_random(1, 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
